// File: rtl/datapath_p2.sv
// Single-bus CPU datapath: GPR file, special registers, bus mux, ALU into Z, and CON branch flag.
// Every register loads from the shared bus (or its dedicated source) on the rising edge of Clock.
module datapath_p2 (
  output logic [31:0] outp,
  input  logic        PCout,
  input  logic        Zhiout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        InPortout,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        OutPortin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        Cout,
  input  logic        CONIn,
  input  logic        Strobe,
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] Mdatain,
  input  logic [31:0] InPort_data
);

  logic [31:0] gpr_q [16];
  logic [31:0] gpr_d [16];
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q, y_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] outport_q, outport_d;
  logic [31:0] inport_q, inport_d;
  logic [31:0] zhi_q, zhi_d;
  logic [31:0] zlo_q, zlo_d;
  logic        con_q, con_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [1:0]  c2;
  logic [3:0]  gpr_sel;
  logic [31:0] gpr_val;
  logic [31:0] c_val;
  logic [31:0] bus;

  assign opcode = ir_q[31:27];
  assign ra     = ir_q[26:23];
  assign rb     = ir_q[22:19];
  assign rc     = ir_q[18:15];
  assign c2     = ir_q[22:21];
  assign c_val  = {{13{ir_q[18]}}, ir_q[18:0]};

  always_comb begin
    gpr_sel = 4'd0;
    if (Gra)      gpr_sel = ra;
    else if (Grb) gpr_sel = rb;
    else if (Grc) gpr_sel = rc;
  end

  assign gpr_val = gpr_q[gpr_sel];

  // BAout treats R0 as a hard zero for base addressing; Rout always sees the stored R0.
  always_comb begin
    bus = '0;
    if (Rout)           bus = gpr_val;
    else if (BAout)     bus = (gpr_sel == 4'd0) ? 32'd0 : gpr_val;
    else if (HIout)     bus = hi_q;
    else if (LOout)     bus = lo_q;
    else if (Zhiout)    bus = zhi_q;
    else if (Zlowout)   bus = zlo_q;
    else if (PCout)     bus = pc_q;
    else if (MDRout)    bus = mdr_q;
    else if (InPortout) bus = inport_q;
    else if (Cout)      bus = c_val;
  end

  assign outp = bus;

  logic signed [63:0] a_ext, b_ext, prod;
  logic signed [31:0] quot, rem;
  logic [63:0]        rot_r, rot_l;
  logic [4:0]         sh;
  logic [31:0]        alu_lo, alu_hi;

  assign a_ext = {{32{y_q[31]}}, y_q};
  assign b_ext = {{32{bus[31]}}, bus};
  assign prod  = a_ext * b_ext;
  assign sh    = bus[4:0];
  assign rot_r = {y_q, y_q} >> sh;
  assign rot_l = {y_q, y_q} << sh;

  always_comb begin
    quot = '0;
    rem  = '0;
    if (bus != 32'd0) begin
      quot = $signed(y_q) / $signed(bus);
      rem  = $signed(y_q) % $signed(bus);
    end
  end

  always_comb begin
    alu_lo = y_q + bus;
    alu_hi = '0;
    if (IncPC) begin
      alu_lo = bus + 32'd1;
    end else begin
      case (opcode)
        5'b00100: alu_lo = y_q - bus;
        5'b01001,
        5'b01100: alu_lo = y_q & bus;
        5'b01010,
        5'b01101: alu_lo = y_q | bus;
        5'b00101: alu_lo = y_q >> sh;
        5'b00110: alu_lo = y_q << sh;
        5'b00111: alu_lo = rot_r[31:0];
        5'b01000: alu_lo = rot_l[63:32];
        5'b01110: begin
          alu_lo = prod[31:0];
          alu_hi = prod[63:32];
        end
        5'b01111: begin
          alu_lo = quot;
          alu_hi = rem;
        end
        5'b10000: alu_lo = 32'd0 - bus;
        5'b10001: alu_lo = ~bus;
        default:  alu_lo = y_q + bus;
      endcase
    end
  end

  logic con_eval;

  always_comb begin
    case (c2)
      2'b00:   con_eval = (bus == 32'd0);
      2'b01:   con_eval = (bus != 32'd0);
      2'b10:   con_eval = ~bus[31];
      default: con_eval = bus[31];
    endcase
  end

  always_comb begin
    for (int i = 0; i < 16; i++) gpr_d[i] = gpr_q[i];
    pc_d      = pc_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    y_d       = y_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    outport_d = outport_q;
    inport_d  = inport_q;
    zhi_d     = zhi_q;
    zlo_d     = zlo_q;
    con_d     = con_q;

    if (Rin)       gpr_d[gpr_sel] = bus;
    if (PCin)      pc_d      = bus;
    if (IRin)      ir_d      = bus;
    if (MARin)     mar_d     = bus;
    if (MDRin)     mdr_d     = Read ? Mdatain : bus;
    if (Yin)       y_d       = bus;
    if (HIin)      hi_d      = bus;
    if (LOin)      lo_d      = bus;
    if (OutPortin) outport_d = bus;
    if (Strobe)    inport_d  = InPort_data;
    if (CONIn)     con_d     = con_eval;
    if (Zin) begin
      zhi_d = alu_hi;
      zlo_d = alu_lo;
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      outport_q <= '0;
      inport_q  <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      con_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) gpr_q[i] <= gpr_d[i];
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      y_q       <= y_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      outport_q <= outport_d;
      inport_q  <= inport_d;
      zhi_q     <= zhi_d;
      zlo_q     <= zlo_d;
      con_q     <= con_d;
    end
  end

  // MAR and OutPort feed memory/pins outside this block; Write is a reserved strobe.
  logic unused_ok;
  assign unused_ok = ^{Write, mar_q, outport_q};

endmodule

// File: tb/tb_datapath_p2.sv
// Directed-vector bench for datapath_p2: register state is observed through the bus output.
module tb_datapath_p2;

  logic [31:0] outp;
  logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
  logic Clock, Clear;
  logic [31:0] Mdatain, InPort_data;

  int n_vec = 0;
  int n_err = 0;

  datapath_p2 dut (
    .outp(outp), .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .CONIn(CONIn), .Strobe(Strobe), .Clock(Clock), .Clear(Clear),
    .Mdatain(Mdatain), .InPort_data(InPort_data)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clr_ctrl();
    {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin} = '0;
    {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe} = '0;
    Clear = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    clr_ctrl();
    #1;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Read = 1'b1; MDRin = 1'b1; Mdatain = v;
    tick();
  endtask

  task automatic load_ir(input logic [31:0] v);
    mdr_load(v);
    MDRout = 1'b1; IRin = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    mdr_load(32'hDEAD_BEEF);
    MDRout = 1'b1; HIin = 1'b1; PCin = 1'b1; Rin = 1'b1; Yin = 1'b1;
    tick();
    IncPC = 1'b1; HIout = 1'b1; Zin = 1'b1; CONIn = 1'b1;
    tick();
    Clear = 1'b1;
    tick();
    n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL reset_idle_bus: got %h expected %h", outp, 32'h0); end
    HIout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected %h", outp, 32'h0); end
    clr_ctrl(); PCout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected %h", outp, 32'h0); end
    clr_ctrl(); Zlowout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL reset_zlow: got %h expected %h", outp, 32'h0); end
    clr_ctrl(); Rout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL reset_r0: got %h expected %h", outp, 32'h0); end
    clr_ctrl(); n_vec++;
    if (dut.con_q !== 1'b0) begin n_err++; $display("FAIL reset_con: got %b expected %b", dut.con_q, 1'b0); end
  endtask

  task automatic test_fetch();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    tick();
    Zlowout = 1'b1; #1; n_vec++;
    if (outp !== 32'h1) begin n_err++; $display("FAIL fetch_zlow: got %h expected %h", outp, 32'h1); end
    PCin = 1'b1;
    tick();
    PCout = 1'b1; #1; n_vec++;
    if (outp !== 32'h1) begin n_err++; $display("FAIL fetch_pc: got %h expected %h", outp, 32'h1); end
    clr_ctrl();
    mdr_load(32'h9160_0023);
    MDRout = 1'b1; #1; n_vec++;
    if (outp !== 32'h9160_0023) begin n_err++; $display("FAIL fetch_mdr: got %h expected %h", outp, 32'h9160_0023); end
    IRin = 1'b1;
    tick();
    Cout = 1'b1; #1; n_vec++;
    if (outp !== 32'h23) begin n_err++; $display("FAIL fetch_ir_c: got %h expected %h", outp, 32'h23); end
    clr_ctrl();
  endtask

  task automatic test_branch();
    mdr_load(32'h8000_0000);
    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
    tick();
    Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1;
    tick();
    n_vec++;
    if (dut.con_q !== 1'b1) begin n_err++; $display("FAIL brmi_taken_con: got %b expected %b", dut.con_q, 1'b1); end
    PCout = 1'b1; Yin = 1'b1;
    tick();
    Cout = 1'b1; Zin = 1'b1;
    tick();
    Zlowout = 1'b1; #1; n_vec++;
    if (outp !== 32'h24) begin n_err++; $display("FAIL brmi_target: got %h expected %h", outp, 32'h24); end
    PCin = 1'b1;
    tick();
    PCout = 1'b1; #1; n_vec++;
    if (outp !== 32'h24) begin n_err++; $display("FAIL brmi_pc: got %h expected %h", outp, 32'h24); end
    clr_ctrl();
    mdr_load(32'h0000_0005);
    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
    tick();
    Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1;
    tick();
    n_vec++;
    if (dut.con_q !== 1'b0) begin n_err++; $display("FAIL brmi_not_taken_con: got %b expected %b", dut.con_q, 1'b0); end
  endtask

  task automatic test_con_table();
    logic [1:0]  c2s [7];
    logic [31:0] bvs [7];
    logic        exp [7];
    c2s = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    bvs = '{32'h0, 32'h7, 32'h0, 32'h7, 32'h8000_0000, 32'h1, 32'h8000_0000};
    exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      load_ir({5'b10010, 4'd2, c2s[i], 21'h23});
      mdr_load(bvs[i]);
      MDRout = 1'b1; CONIn = 1'b1;
      tick();
      n_vec++;
      if (dut.con_q !== exp[i]) begin
        n_err++; $display("FAIL con_c2_%0d_bus_%h: got %b expected %b", c2s[i], bvs[i], dut.con_q, exp[i]);
      end
    end
  endtask

  task automatic test_cout();
    logic [31:0] irs [3];
    logic [31:0] exp [3];
    irs = '{32'h0004_0000, 32'h0003_FFFF, 32'hFFF8_0001};
    exp = '{32'hFFFC_0000, 32'h0003_FFFF, 32'h0000_0001};
    for (int i = 0; i < 3; i++) begin
      load_ir(irs[i]);
      Cout = 1'b1; #1; n_vec++;
      if (outp !== exp[i]) begin n_err++; $display("FAIL cout_%0d: got %h expected %h", i, outp, exp[i]); end
      clr_ctrl();
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t t [16];
    t = '{
      '{5'b00011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h8000_0000},
      '{5'b01110, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{5'b00100, 32'h0000_0005, 32'h0000_0007, 32'h0, 32'hFFFF_FFFE},
      '{5'b01001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hF000_F000},
      '{5'b01010, 32'hF0F0_F0F0, 32'h0F00_0000, 32'h0, 32'hFFF0_F0F0},
      '{5'b00101, 32'h8000_0001, 32'h0000_0004, 32'h0, 32'h0800_0000},
      '{5'b00110, 32'h8000_0001, 32'h0000_0004, 32'h0, 32'h0000_0010},
      '{5'b00111, 32'h8000_0001, 32'h0000_0004, 32'h0, 32'h1800_0000},
      '{5'b01000, 32'h8000_0001, 32'h0000_0004, 32'h0, 32'h0000_0018},
      '{5'b00111, 32'h1234_5678, 32'h0000_0020, 32'h0, 32'h1234_5678},
      '{5'b01111, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{5'b01111, 32'h0000_0005, 32'h0000_0000, 32'h0, 32'h0},
      '{5'b10000, 32'h0000_0009, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF},
      '{5'b10001, 32'h0000_0009, 32'h0000_FFFF, 32'h0, 32'hFFFF_0000},
      '{5'b11111, 32'h0000_0003, 32'h0000_0004, 32'h0, 32'h0000_0007},
      '{5'b01100, 32'h0000_00FF, 32'h0000_0F0F, 32'h0, 32'h0000_000F}
    };
    for (int i = 0; i < 16; i++) begin
      load_ir({t[i].op, 27'd0});
      mdr_load(t[i].a);
      MDRout = 1'b1; Yin = 1'b1;
      tick();
      mdr_load(t[i].b);
      MDRout = 1'b1; Zin = 1'b1;
      tick();
      Zlowout = 1'b1; #1; n_vec++;
      if (outp !== t[i].lo) begin n_err++; $display("FAIL alu_%0d_op%b_lo: got %h expected %h", i, t[i].op, outp, t[i].lo); end
      clr_ctrl(); Zhiout = 1'b1; #1; n_vec++;
      if (outp !== t[i].hi) begin n_err++; $display("FAIL alu_%0d_op%b_hi: got %h expected %h", i, t[i].op, outp, t[i].hi); end
      clr_ctrl();
    end
    // IncPC must override even the 64-bit multiply opcode.
    load_ir({5'b01110, 27'd0});
    mdr_load(32'hFFFF_FFFF);
    MDRout = 1'b1; Yin = 1'b1;
    tick();
    MDRout = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    tick();
    Zlowout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL incpc_wrap_lo: got %h expected %h", outp, 32'h0); end
    clr_ctrl(); Zhiout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL incpc_wrap_hi: got %h expected %h", outp, 32'h0); end
    clr_ctrl();
  endtask

  task automatic test_r0_baout();
    load_ir(32'h0100_0000);
    mdr_load(32'h5);
    MDRout = 1'b1; Rin = 1'b1;
    tick();
    BAout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL baout_r0: got %h expected %h", outp, 32'h0); end
    clr_ctrl(); Rout = 1'b1; #1; n_vec++;
    if (outp !== 32'h5) begin n_err++; $display("FAIL rout_r0: got %h expected %h", outp, 32'h5); end
    clr_ctrl();
    mdr_load(32'h0000_0ABC);
    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
    tick();
    Gra = 1'b1; BAout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0000_0ABC) begin n_err++; $display("FAIL baout_r2: got %h expected %h", outp, 32'h0000_0ABC); end
    clr_ctrl(); Grb = 1'b1; Rout = 1'b1; #1; n_vec++;
    if (outp !== 32'h5) begin n_err++; $display("FAIL grb_r0: got %h expected %h", outp, 32'h5); end
    clr_ctrl();
  endtask

  task automatic test_simultaneous_and_priority();
    mdr_load(32'hA5A5_0F0F);
    MDRout = 1'b1; PCin = 1'b1; HIin = 1'b1; LOin = 1'b1;
    Strobe = 1'b1; InPort_data = 32'hCAFE_BABE;
    tick();
    PCout = 1'b1; #1; n_vec++;
    if (outp !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL simul_pc: got %h expected %h", outp, 32'hA5A5_0F0F); end
    clr_ctrl(); LOout = 1'b1; #1; n_vec++;
    if (outp !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL simul_lo: got %h expected %h", outp, 32'hA5A5_0F0F); end
    clr_ctrl(); InPortout = 1'b1; Cout = 1'b1; #1; n_vec++;
    if (outp !== 32'hCAFE_BABE) begin n_err++; $display("FAIL strobe_inport: got %h expected %h", outp, 32'hCAFE_BABE); end
    clr_ctrl();
    mdr_load(32'h0000_0022);
    MDRout = 1'b1; LOin = 1'b1;
    tick();
    HIout = 1'b1; LOout = 1'b1; #1; n_vec++;
    if (outp !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL prio_hi_over_lo: got %h expected %h", outp, 32'hA5A5_0F0F); end
    clr_ctrl(); Rout = 1'b1; HIout = 1'b1; #1; n_vec++;
    if (outp !== 32'h5) begin n_err++; $display("FAIL prio_rout_over_hi: got %h expected %h", outp, 32'h5); end
    clr_ctrl(); PCout = 1'b1; MDRout = 1'b1; #1; n_vec++;
    if (outp !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL prio_pc_over_mdr: got %h expected %h", outp, 32'hA5A5_0F0F); end
    clr_ctrl();
  endtask

  task automatic test_clear_mid();
    load_ir(32'h9160_0023);
    mdr_load(32'h8000_0055);
    MDRout = 1'b1; PCin = 1'b1; CONIn = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    tick();
    n_vec++;
    if (dut.con_q !== 1'b1) begin n_err++; $display("FAIL clrmid_setup_con: got %b expected %b", dut.con_q, 1'b1); end
    Clear = 1'b1; MDRout = 1'b1; PCin = 1'b1; Zin = 1'b1; IncPC = 1'b1; CONIn = 1'b1;
    tick();
    PCout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL clrmid_pc: got %h expected %h", outp, 32'h0); end
    clr_ctrl(); Zlowout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL clrmid_zlow: got %h expected %h", outp, 32'h0); end
    clr_ctrl(); Zhiout = 1'b1; #1; n_vec++;
    if (outp !== 32'h0) begin n_err++; $display("FAIL clrmid_zhi: got %h expected %h", outp, 32'h0); end
    clr_ctrl(); n_vec++;
    if (dut.con_q !== 1'b0) begin n_err++; $display("FAIL clrmid_con: got %b expected %b", dut.con_q, 1'b0); end
  endtask

  initial begin
    clr_ctrl();
    Mdatain = '0;
    InPort_data = '0;
    Clear = 1'b1;
    tick();
    test_reset();
    test_fetch();
    test_branch();
    test_con_table();
    test_cout();
    test_alu();
    test_r0_baout();
    test_simultaneous_and_priority();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
